// File: rtl/serial_adder_nbit.sv
// Multi-cycle LSB-first adder/subtractor, DIGIT bits per clock.
// Carry is registered between digits; start/busy/done handshake.
module serial_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [31:0]      base;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] s_ins;
  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] s_d;
  logic             c_d;
  logic             c_msb;
  logic             last;

  assign base  = 32'(cnt) * 32'(DIGIT);
  assign a_sh  = a_q >> base;
  assign b_sh  = b_q >> base;
  assign a_d   = a_sh[DIGIT-1:0];
  assign b_d   = b_sh[DIGIT-1:0];
  assign {c_d, s_d} = {1'b0, a_d} + {1'b0, b_d}
                    + (DIGIT+1)'(carry_q);
  // Carry into the top bit recovered from the sum bit itself.
  assign c_msb = s_d[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
  assign mask  = WIDTH'({DIGIT{1'b1}}) << base;
  assign s_ins = WIDTH'(s_d) << base;
  assign last  = (cnt == CW'(NDIG - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b ^ {WIDTH{i_sub}};
            carry_q <= i_cin ^ i_sub;
            cnt     <= '0;
            o_busy  <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          o_sum   <= (o_sum & ~mask) | s_ins;
          carry_q <= c_d;
          cnt     <= cnt + CW'(1);
          if (last) begin
            o_carry    <= c_d;
            o_overflow <= c_msb ^ c_d;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: DIGIT=1,4,16 side by side
// against an arithmetic reference model.
module tb_serial_adder_nbit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_cin = 1'b0;
  logic        i_sub = 1'b0;

  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] sum_w  [3];
  logic        c_w    [3];
  logic        v_w    [3];

  int m_pass = 0;
  int m_total = 0;
  int d_pass = 0;
  int d_total = 0;

  always #5 i_clk = ~i_clk;

  serial_adder_nbit #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_sum(sum_w[0]),
    .o_carry(c_w[0]), .o_overflow(v_w[0])
  );

  serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_sum(sum_w[1]),
    .o_carry(c_w[1]), .o_overflow(v_w[1])
  );

  serial_adder_nbit #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
    .o_busy(busy_w[2]), .o_done(done_w[2]), .o_sum(sum_w[2]),
    .o_carry(c_w[2]), .o_overflow(v_w[2])
  );

  function automatic int ndig_of(int k);
    case (k)
      0:       return 16;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Returns {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_calc(logic [15:0] a, logic [15:0] b,
                                           logic cin, logic sub);
    int ua, ub, ur, sa, sb, sr;
    logic c, v;
    ua = int'({16'b0, a});
    ub = int'({16'b0, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub - int'({31'b0, cin});
      sr = sa - sb - int'({31'b0, cin});
      c  = (ur >= 0);
    end else begin
      ur = ua + ub + int'({31'b0, cin});
      sr = sa + sb + int'({31'b0, cin});
      c  = (ur >= 65536);
    end
    v = (sr > 32767) || (sr < -32768);
    return {v, c, ur[15:0]};
  endfunction

  int          phase  [3] = '{-1, -1, -1};
  logic        e_busy [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_done [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_c    [3] = '{1'b0, 1'b0, 1'b0};
  logic        e_v    [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] e_sum  [3] = '{16'h0, 16'h0, 16'h0};
  logic [17:0] pend   [3] = '{18'h0, 18'h0, 18'h0};

  // Reference model: accept when idle, result after NDIG edges.
  always @(posedge i_clk or negedge i_rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!i_rst_n) begin
        phase[k]  = -1;
        e_busy[k] = 1'b0;
        e_done[k] = 1'b0;
        e_sum[k]  = '0;
        e_c[k]    = 1'b0;
        e_v[k]    = 1'b0;
      end else if (phase[k] < 0) begin
        if (i_start) begin
          phase[k]  = 0;
          pend[k]   = ref_calc(i_a, i_b, i_cin, i_sub);
          e_busy[k] = 1'b1;
        end
      end else begin
        phase[k] = phase[k] + 1;
        if (phase[k] == ndig_of(k)) begin
          e_busy[k] = 1'b0;
          e_done[k] = 1'b1;
          {e_v[k], e_c[k], e_sum[k]} = pend[k];
        end else if (phase[k] > ndig_of(k)) begin
          phase[k]  = -1;
          e_done[k] = 1'b0;
        end
      end
    end
  end

  task automatic mchk(string name, int k, logic [15:0] act, logic [15:0] exp);
    m_total++;
    if (act === exp) m_pass++;
    else $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, act, exp);
  endtask

  task automatic dchk(string name, int k, int act, int exp);
    d_total++;
    if (act == exp) d_pass++;
    else $display("FAIL %s dut%0d t=%0t got %0h want %0h", name, k, $time, act, exp);
  endtask

  always @(negedge i_clk) begin
    for (int k = 0; k < 3; k++) begin
      mchk("busy", k, 16'(busy_w[k]), 16'(e_busy[k]));
      mchk("done", k, 16'(done_w[k]), 16'(e_done[k]));
      if (!e_busy[k]) begin
        mchk("sum", k, sum_w[k], e_sum[k]);
        mchk("carry", k, 16'(c_w[k]), 16'(e_c[k]));
        mchk("ovf", k, 16'(v_w[k]), 16'(e_v[k]));
      end
    end
  end

  task automatic op_lit(logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                        logic [15:0] es, logic ec, logic ev);
    int done_at [3];
    int busy_n  [3];
    dchk("model", 0, int'(ref_calc(a, b, cin, sub)), int'({ev, ec, es}));
    for (int k = 0; k < 3; k++) begin
      done_at[k] = -1;
      busy_n[k]  = 0;
    end
    @(negedge i_clk);
    i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge i_clk);
      if (n == 1) begin
        i_start = 1'b0;
        i_a = ~a;
        i_b = 16'($urandom);
        i_sub = ~sub;
      end
      for (int k = 0; k < 3; k++) begin
        if (busy_w[k]) busy_n[k]++;
        if (done_w[k] && done_at[k] < 0) done_at[k] = n;
      end
    end
    for (int k = 0; k < 3; k++) begin
      dchk("latency", k, done_at[k], ndig_of(k) + 1);
      dchk("busy_cycles", k, busy_n[k], ndig_of(k));
      dchk("lit_sum", k, int'(sum_w[k]), int'(es));
      dchk("lit_carry", k, int'(c_w[k]), int'(ec));
      dchk("lit_ovf", k, int'(v_w[k]), int'(ev));
    end
  endtask

  initial begin
    int last_d [3];
    repeat (2) @(negedge i_clk);
    for (int k = 0; k < 3; k++) begin
      dchk("rst_sum", k, int'(sum_w[k]), 0);
      dchk("rst_busy", k, int'(busy_w[k]), 0);
      dchk("rst_done", k, int'(done_w[k]), 0);
    end
    i_rst_n = 1'b1;

    op_lit(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    op_lit(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_lit(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op_lit(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op_lit(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op_lit(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Abort mid-operation with an asynchronous reset.
    @(negedge i_clk);
    i_a = 16'hABCD; i_b = 16'h1357; i_cin = 1'b1; i_sub = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      dchk("abort_busy", k, int'(busy_w[k]), 0);
      dchk("abort_done", k, int'(done_w[k]), 0);
      dchk("abort_sum", k, int'(sum_w[k]), 0);
      dchk("abort_carry", k, int'(c_w[k]), 0);
      dchk("abort_ovf", k, int'(v_w[k]), 0);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    #3 i_rst_n = 1'b1;
    op_lit(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Start held high: back-to-back operations.
    for (int k = 0; k < 3; k++) last_d[k] = -1;
    @(negedge i_clk);
    i_start = 1'b1;
    for (int n = 0; n < 80; n++) begin
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      i_cin = 1'($urandom);
      i_sub = 1'($urandom);
      @(negedge i_clk);
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          if (last_d[k] >= 0) dchk("spacing", k, n - last_d[k], ndig_of(k) + 2);
          last_d[k] = n;
        end
      end
    end
    i_start = 1'b0;
    repeat (20) @(negedge i_clk);

    for (int t = 0; t < 1000; t++) begin
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      if (t % 8 == 0) i_b = 16'($urandom_range(0, 3));
      i_cin = 1'($urandom);
      i_sub = 1'($urandom);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'($urandom);
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      i_sub = 1'($urandom);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (18) @(negedge i_clk);
    end

    $display("%0d/%0d checks passed", m_pass + d_pass, m_total + d_total);
    $finish;
  end

endmodule
